// File: rtl/ias_pkg.sv
// Shared definitions for the IAS scan controller and datapath: opcodes,
// controller state encoding and the default register width.
package ias_pkg;

  localparam int IAS_WIDTH = 32;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_DUMP = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_RESP  = 2'd3
  } ias_state_e;

endpackage

// File: rtl/ias_datapath.sv
// IAS datapath: scan-enabled counter register with a parallel-load mux and
// +1 feedback. Scan shifting has priority over the functional enable.
module IAS_datapath import ias_pkg::*; #(
  parameter int WIDTH = IAS_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_en,
  input  logic             reg_sel,
  input  logic             scan_ce,
  input  logic             sen,
  input  logic             sin,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             sout
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (scan_ce && sen) begin
      q_d = {q_q[WIDTH-2:0], sin};
    end else if (reg_en) begin
      q_d = reg_sel ? data_in : q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign data_out = q_q;
  assign sout     = q_q[WIDTH-1];

endmodule

// File: rtl/ias_scan_ctrl.sv
// Command sequencer for the IAS datapath: LOAD, STEP, DUMP (circular scan
// read) and SWAP (scan exchange), one command at a time, result on rsp_*.
module ias_scan_ctrl import ias_pkg::*; #(
  parameter int WIDTH = IAS_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  // Both ports: a transfer happens on a rising edge where valid && ready;
  // the sender holds valid and its payload stable until that edge.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] dp_data_in,
  input  logic [WIDTH-1:0] dp_data_out,
  output logic             dp_reg_en,
  output logic             dp_reg_sel,
  output logic             dp_scan_ce,
  output logic             dp_sen,
  output logic             dp_sin,
  input  logic             dp_sout,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  ias_state_e       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [CW-1:0]    shift_cnt_q, shift_cnt_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    step_cnt_d  = step_cnt_q;
    shift_cnt_d = shift_cnt_q;
    cap_d       = cap_q;
    sh_d        = sh_q;
    rsp_data_d  = rsp_data_q;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    dp_data_in  = '0;
    dp_reg_en   = 1'b0;
    dp_reg_sel  = 1'b0;
    dp_scan_ce  = 1'b0;
    dp_sen      = 1'b0;
    dp_sin      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d        = cmd_op;
          data_d      = cmd_data;
          step_cnt_d  = (cmd_op == OP_STEP) ? cmd_data : '0;
          sh_d        = (cmd_op == OP_SWAP) ? cmd_data : '0;
          shift_cnt_d = '0;
          cap_d       = '0;
          state_d     = (cmd_op == OP_LOAD || cmd_op == OP_STEP) ? ST_EXEC : ST_SHIFT;
        end
      end

      ST_EXEC: begin
        dp_data_in = data_q;
        if (op_q == OP_LOAD) begin
          dp_reg_en  = 1'b1;
          dp_reg_sel = 1'b1;
          rsp_data_d = data_q;
          state_d    = ST_RESP;
        end else if (step_cnt_q != '0) begin
          dp_reg_en  = 1'b1;
          step_cnt_d = step_cnt_q - WIDTH'(1);
        end else begin
          // All increments have landed; the register output is the result.
          rsp_data_d = dp_data_out;
          state_d    = ST_RESP;
        end
      end

      ST_SHIFT: begin
        dp_scan_ce = 1'b1;
        dp_sen     = 1'b1;
        dp_sin     = (op_q == OP_SWAP) ? sh_q[WIDTH-1] : dp_sout;
        cap_d      = {cap_q[WIDTH-2:0], dp_sout};
        sh_d       = sh_q << 1;
        if (shift_cnt_q == CW'(WIDTH - 1)) begin
          rsp_data_d = cap_d;
          state_d    = ST_RESP;
        end else begin
          shift_cnt_d = shift_cnt_q + CW'(1);
        end
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOAD;
      data_q      <= '0;
      step_cnt_q  <= '0;
      shift_cnt_q <= '0;
      cap_q       <= '0;
      sh_q        <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      step_cnt_q  <= step_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      cap_q       <= cap_d;
      sh_q        <= sh_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_data  = rsp_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ias_scan_ctrl.sv
// Directed bench for ias_scan_ctrl driving IAS_datapath; responses are
// checked by a monitor against queued data and response-cycle expectations.
module tb_ias_scan_ctrl;
  import ias_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [W-1:0] dp_data_in;
  logic [W-1:0] dp_data_out;
  logic         dp_reg_en, dp_reg_sel, dp_scan_ce, dp_sen, dp_sin, dp_sout;
  logic [1:0]   dbg_state;

  ias_scan_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .dp_data_in(dp_data_in), .dp_data_out(dp_data_out),
    .dp_reg_en(dp_reg_en), .dp_reg_sel(dp_reg_sel), .dp_scan_ce(dp_scan_ce),
    .dp_sen(dp_sen), .dp_sin(dp_sin), .dp_sout(dp_sout),
    .dbg_state(dbg_state)
  );

  IAS_datapath #(.WIDTH(W)) u_dp (
    .clk(clk), .reset(reset),
    .reg_en(dp_reg_en), .reg_sel(dp_reg_sel), .scan_ce(dp_scan_ce),
    .sen(dp_sen), .sin(dp_sin), .data_in(dp_data_in),
    .data_out(dp_data_out), .sout(dp_sout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           sen_cnt  = 0;
  logic         prev_valid = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (dp_sen) sen_cnt++;
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        if (cyc_q.size() == 0) fail_now("unexpected_rsp_valid");
        else check("rsp_cycle", W'(cyc), W'(cyc_q.pop_front()));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_rsp_data");
        else check("rsp_data", rsp_data, exp_q.pop_front());
      end
      prev_valid = rsp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] data,
                          input logic [W-1:0] exp, input int lat, input bit push);
    bit ok;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("cmd_accept_timeout");
    else if (push) begin
      exp_q.push_back(exp);
      cyc_q.push_back(cyc + lat);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && cyc_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail_now("rsp_timeout");
      exp_q.delete();
      cyc_q.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] ctrls();
    return W'({dp_reg_en, dp_reg_sel, dp_scan_ce, dp_sen, dp_sin});
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    int h;
    bit ok;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_LOAD;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", W'(cmd_ready), 1);
    check("reset_rsp_valid", W'(rsp_valid), 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_ctrls", ctrls(), 0);
    check("reset_dp_data_in", dp_data_in, 0);
    check("reset_state", W'(dbg_state), W'(ST_IDLE));

    // LOAD
    send_cmd(OP_LOAD, 32'h1234_5678, 32'h1234_5678, 2, 1);
    wait_drain();
    check("load_dp_out", dp_data_out, 32'h1234_5678);

    // STEP wrapping through zero, then STEP 0
    send_cmd(OP_LOAD, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 2, 1);
    send_cmd(OP_STEP, 32'd3, 32'h0000_0001, 5, 1);
    wait_drain();
    send_cmd(OP_STEP, 32'd0, 32'h0000_0001, 2, 1);
    wait_drain();
    check("step0_dp_out", dp_data_out, 32'h0000_0001);

    // DUMP is non-destructive
    send_cmd(OP_LOAD, 32'hA5C3_0F81, 32'hA5C3_0F81, 2, 1);
    wait_drain();
    s0 = sen_cnt;
    send_cmd(OP_DUMP, 32'hFFFF_0000, 32'hA5C3_0F81, W + 1, 1);
    wait_drain();
    check("dump_dp_out", dp_data_out, 32'hA5C3_0F81);
    check("dump_sen_cycles", W'(sen_cnt - s0), 32);

    // SWAP
    send_cmd(OP_LOAD, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2, 1);
    send_cmd(OP_SWAP, 32'h0BAD_F00D, 32'hDEAD_BEEF, W + 1, 1);
    wait_drain();
    check("swap_dp_out", dp_data_out, 32'h0BAD_F00D);

    // Backpressure on a DUMP response with a competing command
    @(posedge clk); #1 rsp_ready = 1'b0;
    send_cmd(OP_DUMP, 32'h0, 32'h0BAD_F00D, W + 1, 1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("bp_rsp_valid_timeout");
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 32'h1111_1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", W'(rsp_valid), 1);
      check("bp_rsp_data", rsp_data, 32'h0BAD_F00D);
      check("bp_cmd_ready", W'(cmd_ready), 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    h = cyc;
    check("hs_cmd_ready", W'(cmd_ready), 0);
    exp_q.push_back(32'h1111_1111);
    cyc_q.push_back(h + 3);
    @(negedge clk);
    check("post_hs_cmd_ready", W'(cmd_ready), 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_drain();
    check("bp_load_dp_out", dp_data_out, 32'h1111_1111);

    // Reset in the middle of a DUMP
    send_cmd(OP_DUMP, 32'h0, 32'h0, 0, 0);
    repeat (16) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset_ctrls", ctrls(), 0);
    check("midreset_rsp_valid", W'(rsp_valid), 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("after_reset_cmd_ready", W'(cmd_ready), 1);
    check("after_reset_rsp_data", rsp_data, 0);
    send_cmd(OP_LOAD, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 2, 1);
    wait_drain();
    check("after_reset_dp_out", dp_data_out, 32'h5A5A_5A5A);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
